// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and index helper for mem_responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memresp_state_t;

  localparam int WORD_W = 32;

  // Number of word-index bits needed to address a memory of 'depth' words
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - 4-bit loadable down-counter timing the wait states
module wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  assign zero = (cnt == 4'd0);

  // Load takes precedence; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory with req/ready handshake and WAITS wait states; optional MEMRESP_ALIGN_CHECK_EN
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              we,
  input  logic [31:0]       adr,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int IW     = idx_width(DEPTH);
  localparam int LOAD_I = (WAITS > 0) ? WAITS - 1 : 0;

  memresp_state_t state, next_state;

  logic [31:0]       adr_q;
  logic              we_q;
  logic [WORD_W-1:0] wd_q;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept;
  logic              cnt_zero;
  logic              enter_resp;
  logic              mis;
  logic              do_write;
  logic              do_read;
  logic [31:0]       cur_adr;
  logic              cur_we;
  logic [WORD_W-1:0] cur_wd;
  logic [IW-1:0]     cur_idx;
  logic              unused_adr;

  // With zero wait states the access completes on the acceptance edge,
  // so the live inputs are used while still in IDLE
  assign cur_adr    = (state == IDLE) ? adr : adr_q;
  assign cur_we     = (state == IDLE) ? we  : we_q;
  assign cur_wd     = (state == IDLE) ? wd  : wd_q;
  assign cur_idx    = cur_adr[IW+1:2];
  assign unused_adr = ^{cur_adr[31:IW+2], cur_adr[1:0]};

  assign enter_resp = (next_state == RESP) && (state != RESP);
  assign do_write   = enter_resp && cur_we && !mis;
  assign do_read    = enter_resp && !cur_we && !mis;

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

`ifdef MEMRESP_ALIGN_CHECK_EN
  assign mis = (cur_adr[1:0] != 2'b00);
  assign err = (state == RESP) && (adr_q[1:0] != 2'b00);
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif

  wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (4'(LOAD_I)),
    .en       (state == WAIT),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; requests are only sampled in IDLE
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          next_state = (WAITS > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if (!reset) begin
      adr_q <= 32'd0;
      we_q  <= 1'b0;
      wd_q  <= '0;
    end else if (accept) begin
      adr_q <= adr;
      we_q  <= we;
      wd_q  <= wd;
    end
  end

  // Array write on the edge entering RESP; reset aborts a pending write
  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      mem[cur_idx] <= cur_wd;
    end
  end

  // Read data register, only updated by a completing read
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd <= '0;
    end else if (do_read) begin
      rd <= mem[cur_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (WAITS=2 and WAITS=0 instances)
module tb_mem_responder;

  localparam int WAITS_A = 2;
  localparam int WAITS_B = 0;

`ifdef MEMRESP_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, ready_a, busy_a, err_a;
  logic [31:0] adr_a, wd_a, rd_a;
  logic        req_b, we_b, ready_b, busy_b, err_b;
  logic [31:0] adr_b, wd_b, rd_b;

  exp_t        sbq[$];
  logic [31:0] model [2][64];
  logic [31:0] last_rd [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .WAITS(WAITS_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_a), .we(we_a), .adr(adr_a), .wd(wd_a),
    .rd(rd_a), .ready(ready_a), .busy(busy_a), .err(err_a)
  );

  mem_responder #(.DEPTH(64), .WAITS(WAITS_B)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_b), .we(we_b), .adr(adr_b), .wd(wd_b),
    .rd(rd_b), .ready(ready_b), .busy(busy_b), .err(err_b)
  );

  task automatic drive(input int s, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      req_a = v; we_a = w; adr_a = a; wd_a = d;
    end else begin
      req_b = v; we_b = w; adr_b = a; wd_b = d;
    end
  endtask

  task automatic sample(input int s, output logic r, output logic b, output logic e, output logic [31:0] d);
    if (s == 0) begin
      r = ready_a; b = busy_a; e = err_a; d = rd_a;
    end else begin
      r = ready_b; b = busy_b; e = err_b; d = rd_b;
    end
  endtask

  // Reference model: update memory / read data and queue the expected response
  function automatic void expect_access(input int s, input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input int lat);
    logic mis;
    int   idx;
    exp_t e;
    mis = ALIGN_EN && (a[1:0] != 2'b00);
    idx = int'(a[7:2]);
    if (!mis && w) model[s][idx] = d;
    if (!mis && !w) last_rd[s] = model[s][idx];
    e.rd  = last_rd[s];
    e.err = mis;
    e.lat = lat;
    sbq.push_back(e);
  endfunction

  task automatic run_access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, input string nm);
    exp_t        e;
    int          lat;
    int          bcnt;
    logic        r, b, er;
    logic [31:0] q;
    expect_access(s, w, a, d, ((s == 0) ? WAITS_A : WAITS_B) + 1);
    drive(s, 1'b1, w, a, d);
    @(posedge clk);
    lat = 0; bcnt = 0; r = 1'b0; er = 1'b0; q = '0;
    while (!r && lat < 40) begin
      @(negedge clk);
      lat++;
      sample(s, r, b, er, q);
      if (b) bcnt++;
    end
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    e = sbq.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, e.lat);
    end
    n_cmp++;
    if (bcnt !== e.lat) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bcnt, e.lat);
    end
    n_cmp++;
    if (q !== e.rd) begin
      n_bad++; $display("FAIL %s rd: got %h want %h", nm, q, e.rd);
    end
    n_cmp++;
    if (er !== e.err) begin
      n_bad++; $display("FAIL %s err: got %b want %b", nm, er, e.err);
    end
    @(negedge clk);
    sample(s, r, b, er, q);
    n_cmp++;
    if ({r, b, er} !== 3'b000) begin
      n_bad++; $display("FAIL %s after_ready {ready,busy,err}: got %b want 000", nm, {r, b, er});
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready_a, busy_a, err_a, rd_a} !== 35'd0) begin
      n_bad++; $display("FAIL reset_a {ready,busy,err,rd}: got %h want 0", {ready_a, busy_a, err_a, rd_a});
    end
    n_cmp++;
    if ({ready_b, busy_b, err_b, rd_b} !== 35'd0) begin
      n_bad++; $display("FAIL reset_b {ready,busy,err,rd}: got %h want 0", {ready_b, busy_b, err_b, rd_b});
    end
    reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    run_access(0, 1'b1, 32'h10, 32'hCAFEF00D, "wr_10");
    run_access(0, 1'b0, 32'h10, 32'h0, "rd_10");
  endtask

  task automatic test_zero_wait;
    run_access(1, 1'b1, 32'h4, 32'h12345678, "w0_wr_4");
    run_access(1, 1'b0, 32'h4, 32'h0, "w0_rd_4");
  endtask

  task automatic test_alias;
    run_access(0, 1'b1, 32'h100, 32'hAAAA5555, "alias_wr_100");
    run_access(0, 1'b0, 32'h0, 32'h0, "alias_rd_0");
  endtask

  task automatic test_reset_abort;
    run_access(0, 1'b1, 32'h8, 32'h11112222, "pre_wr_8");
    drive(0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ready_a, busy_a, err_a, rd_a} !== 35'd0) begin
      n_bad++; $display("FAIL abort_reset {ready,busy,err,rd}: got %h want 0", {ready_a, busy_a, err_a, rd_a});
    end
    reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    run_access(0, 1'b0, 32'h8, 32'h0, "abort_rd_8");
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    int          lat;
    int          k;
    logic        r, b, er;
    logic [31:0] q;
    expect_access(0, 1'b0, 32'h10, 32'h0, WAITS_A + 1);
    expect_access(0, 1'b0, 32'h100, 32'h0, 4);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    lat = 0; r = 1'b0; er = 1'b0; q = '0;
    while (!r && lat < 40) begin
      @(negedge clk);
      lat++;
      sample(0, r, b, er, q);
    end
    e = sbq.pop_front();
    n_cmp++;
    if (lat !== e.lat || q !== e.rd) begin
      n_bad++; $display("FAIL b2b_first lat/rd: got %0d/%h want %0d/%h", lat, q, e.lat, e.rd);
    end
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    k = 0; r = 1'b0;
    while (!r && k < 40) begin
      @(negedge clk);
      k++;
      sample(0, r, b, er, q);
      if (k == 1) begin
        n_cmp++;
        if ({r, b} !== 2'b00) begin
          n_bad++; $display("FAIL b2b_bubble {ready,busy}: got %b want 00", {r, b});
        end
      end
      if (k == 2) drive(0, 1'b0, 1'b0, 32'h100, 32'h0);
      if (k == 3) drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    e = sbq.pop_front();
    n_cmp++;
    if (k !== e.lat) begin
      n_bad++; $display("FAIL b2b_second ready_gap: got %0d want %0d", k, e.lat);
    end
    n_cmp++;
    if (q !== e.rd) begin
      n_bad++; $display("FAIL b2b_second rd: got %h want %h", q, e.rd);
    end
    repeat (2) begin
      @(negedge clk);
      sample(0, r, b, er, q);
      n_cmp++;
      if ({r, b} !== 2'b00) begin
        n_bad++; $display("FAIL b2b_no_extra {ready,busy}: got %b want 00", {r, b});
      end
    end
  endtask

  task automatic test_align;
    run_access(0, 1'b1, 32'h12, 32'h1, "align_wr_12");
    run_access(0, 1'b0, 32'h11, 32'h0, "align_rd_11");
    run_access(0, 1'b0, 32'h10, 32'h0, "align_rd_10");
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_zero_wait;
    test_alias;
    test_reset_abort;
    test_back_to_back;
    test_align;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed unified memory that serves the multicycle CPU core's memory port (address, write data, write enable, read data) through a request/ready handshake.
- Each access takes a configurable number of wait states, so the core's controller can be validated against non-ideal memory latency.
- Sits between the core and the top level; replaces a zero-latency memory model.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096
- WAITS, 2, wait-state cycles inserted per access; 0..15

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- req_valid  input  1  initiator requests an access; held high until ready is seen
- we  input  1  1 = write, 0 = read; sampled on acceptance
- adr  input  32  byte address; sampled on acceptance
- wd  input  32  write data; sampled on acceptance
- rd  output  32  read data; valid when ready=1 for a read
- ready  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after acceptance until the ready cycle inclusive
- err  output  1  misalignment flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid=1, latch adr, we and wd.
  - Go to WAIT if WAITS>0; otherwise go to RESP.
- WAIT:
  - Down-counter is loaded with WAITS-1 on acceptance and decrements each cycle.
  - Go to RESP when the count reaches 0.
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE.
- Latency: a request accepted at edge N produces ready high during cycle N+1+WAITS.
- Index: idx = latched adr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses alias (wrap around) modulo DEPTH*4.
- Write:
  - The memory array is written on the edge entering RESP.
  - A read at the same index in the next transaction returns the new data.
- Read:
  - rd is registered with mem[idx] on the edge entering RESP.
  - rd holds its value until the next read completes; writes do not change rd.
- req_valid sampling:
  - req_valid is sampled only in IDLE.
  - A request present during WAIT or RESP is ignored; there is one bubble cycle minimum between transactions.
  - The initiator drops req_valid in the cycle after it sees ready. If it stays high, a new transaction is accepted.
- If req_valid drops mid-transaction, the transaction still completes, including the write.
- Reset values: state=IDLE, rd=0, ready=0, busy=0, err=0, counter=0, latched registers=0.
  - Reset mid-transaction aborts the access; a pending write is not performed.
  - Memory contents are not cleared by reset.
- Reset has priority over every other event on the same edge.

Optional Feature:
- Macro: MEMRESP_ALIGN_CHECK_EN.
- Defined:
  - If the latched adr[1:0]!=0, err=1 coincident with ready.
  - The write is suppressed and rd is left unchanged.
  - Timing is identical to a normal access.
- Undefined: adr[1:0] is ignored, err is tied to 0, and no checking logic is built.

Decomposition:
- Package mem_pkg:
  - typedef enum logic [1:0] memresp_state_t {IDLE, WAIT, RESP}
  - localparam WORD_W=32
  - function clog2-based index width helper
- Sub-module wait_counter (4-bit loadable down-counter with load, en and zero outputs), instantiated once.

Test Plan:
- Default parameters: write adr=0x10 wd=0xCAFEF00D, then read adr=0x10 -> ready exactly 3 cycles after each acceptance edge, rd=0xCAFEF00D, busy high for 3 cycles.
- WAITS=0: read immediately after a write to adr=0x4 (wd=0x12345678) -> ready in the cycle after acceptance, rd=0x12345678.
- Aliasing with DEPTH=64: write 0xAAAA5555 to adr=0x100, read adr=0x0 -> rd=0xAAAA5555.
- Reset low during WAIT of a write of 0xDEADBEEF to adr=0x8, then read 0x8 -> read returns the prior contents; ready, busy and rd are all 0 in the cycle after reset.
- req_valid held high across ready -> second transaction accepted in the IDLE cycle after RESP, next ready 4 cycles after the first; req_valid toggled during WAIT is ignored.
- MEMRESP_ALIGN_CHECK_EN defined: write adr=0x12 wd=0x1 -> err=1 with ready and memory unchanged; read adr=0x11 -> err=1 and rd unchanged. Macro undefined: same accesses give err=0 and the write lands at word 4.
